// File: rtl/hmmm_regfile_mp.sv
// hmmm_regfile_mp: parametrised multi-read-port two-phase register file.
// Optional per-entry parity: define HMMM_REGFILE_PARITY_EN.
module hmmm_regfile_mp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                            ph1,
  input  logic                            ph2,
  input  logic                            reset,
  input  logic                            we,
  input  logic [$clog2(DEPTH)-1:0]        wa,
  input  logic [WIDTH-1:0]                wd,
  input  logic                            par_inject,
  input  logic [NREAD*$clog2(DEPTH)-1:0]  ra,
  output logic [NREAD*WIDTH-1:0]          rd,
  output logic                            busy,
  output logic                            wr_drop,
  output logic [NREAD-1:0]                parity_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  // master (ph2) and slave (ph1) halves of each state flop
  state_t          state_m, state_s, state_n;
  logic [AW-1:0]   ptr_m, ptr_s, ptr_n;
  logic            drop_m, drop_s, drop_n;

  logic [WIDTH-1:0] mem [DEPTH];

  logic            ready;
  logic            wa_zero;
  logic            wr_ok;
  logic            clr_wr;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [WIDTH-1:0] mem_wd;

  assign ready   = (state_s == S_READY);
  assign busy    = ~ready;
  assign wr_drop = drop_s;
  assign wa_zero = (ZERO_REG != 0) && (wa == '0);
  assign wr_ok   = ready && we && !reset && !wa_zero;
  assign clr_wr  = !reset && !ready;

  // next state, clear sequencing and array write selection
  always_comb begin
    state_n = state_s;
    ptr_n   = ptr_s;
    drop_n  = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    if (reset) begin
      state_n = S_CLEAR;
      ptr_n   = '0;
    end else if (!ready) begin
      mem_we = 1'b1;
      mem_wa = ptr_s;
      mem_wd = '0;
      ptr_n  = ptr_s + 1'b1;
      drop_n = we;
      if (ptr_s == AW'(DEPTH - 1))
        state_n = S_READY;
    end else begin
      mem_we = wr_ok;
      drop_n = we && wa_zero;
    end
  end

  // master latch closes at the end of ph2, sampling reset
  always_ff @(negedge ph2) begin
    state_m <= state_n;
    ptr_m   <= ptr_n;
    drop_m  <= drop_n;
  end

  // slave latch presents the new state from ph1 onward
  always_ff @(posedge ph1) begin
    state_s <= state_m;
    ptr_s   <= ptr_m;
    drop_s  <= drop_m;
  end

  // array write commits during ph2
  always_ff @(negedge ph2) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

`ifdef HMMM_REGFILE_PARITY_EN
  logic             mem_p [DEPTH];
  logic             mem_wp;
  logic [NREAD-1:0] perr_hit;
  logic [NREAD-1:0] perr_m, perr_s;

  assign mem_wp     = clr_wr ? 1'b0 : (^wd ^ par_inject);
  assign parity_err = perr_s;

  // parity bit stored alongside its data word
  always_ff @(negedge ph2) begin
    if (mem_we)
      mem_p[mem_wa] <= mem_wp;
  end

  // sticky error capture, cleared only by reset
  always_ff @(negedge ph2) begin
    if (reset)
      perr_m <= '0;
    else
      perr_m <= perr_s | (ready ? perr_hit : '0);
  end

  // error flags become visible at ph1
  always_ff @(posedge ph1) begin
    perr_s <= perr_m;
  end
`else
  logic unused_par;
  assign unused_par = par_inject;
  assign parity_err = '0;
`endif

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          z;
    logic          byp;

    assign a   = ra[g*AW +: AW];
    assign z   = (ZERO_REG != 0) && (a == '0);
    assign byp = (BYPASS != 0) && wr_ok && (a == wa);

    assign rd[g*WIDTH +: WIDTH] =
      busy ? '0 :
      z    ? '0 :
      byp  ? wd : mem[a];

`ifdef HMMM_REGFILE_PARITY_EN
    assign perr_hit[g] = !z && !byp &&
                         ((^mem[a]) != mem_p[a]);
`endif
  end

endmodule

// File: tb/tb_hmmm_regfile_mp.sv
// tb_hmmm_regfile_mp: directed checks of the two-phase register file.
// Two instances share stimulus: bypass enabled (b) and disabled (n).
module tb_hmmm_regfile_mp;

  logic        ph1 = 1'b0;
  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        par_inject = 1'b0;
  logic [2:0]  wa = '0;
  logic [7:0]  wd = '0;
  logic [5:0]  ra = '0;

  logic [15:0] rd_b, rd_n;
  logic        busy_b, busy_n;
  logic        drop_b, drop_n;
  logic [1:0]  perr_b, perr_n;
  logic [1:0]  perr_exp;

  int n_chk = 0;
  int n_err = 0;

  hmmm_regfile_mp #(
    .WIDTH(8), .DEPTH(8), .NREAD(2),
    .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .we(we), .wa(wa), .wd(wd),
    .par_inject(par_inject), .ra(ra),
    .rd(rd_b), .busy(busy_b),
    .wr_drop(drop_b), .parity_err(perr_b)
  );

  hmmm_regfile_mp #(
    .WIDTH(8), .DEPTH(8), .NREAD(2),
    .ZERO_REG(1), .BYPASS(0)
  ) u_nb (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .we(we), .wa(wa), .wd(wd),
    .par_inject(par_inject), .ra(ra),
    .rd(rd_n), .busy(busy_n),
    .wr_drop(drop_n), .parity_err(perr_n)
  );

  // non-overlapping two-phase clock, 40-unit cycle
  always begin
    #5  ph1 = 1'b1;
    #10 ph1 = 1'b0;
    #5  ph2 = 1'b1;
    #10 ph2 = 1'b0;
    #10;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge ph1);
    #1;
  endtask

  task automatic fin();
    @(negedge ph2);
    #2;
  endtask

  initial begin
`ifdef HMMM_REGFILE_PARITY_EN
    perr_exp = 2'b10;
`else
    perr_exp = 2'b00;
`endif
    ra = {3'd4, 3'd1};

    // reset held for three cycles
    mid(); fin();
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_busy_b", busy_b, 1);
      chk("rst_busy_n", busy_n, 1);
      chk("rst_drop", drop_b, 0);
      chk("rst_rd", rd_b, 0);
      chk("rst_perr", perr_b, 0);
      fin();
    end

    // clear sequence, with a write issued while busy
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we = (i == 3);
      wa = 3'd1;
      wd = 8'h99;
      mid();
      chk("clr_busy_b", busy_b, 1);
      chk("clr_busy_n", busy_n, 1);
      chk("clr_rd_b", rd_b, 0);
      chk("clr_rd_n", rd_n, 0);
      if (i == 4) begin
        chk("busy_drop_b", drop_b, 1);
        chk("busy_drop_n", drop_n, 1);
      end
      if (i == 5)
        chk("busy_drop_off", drop_b, 0);
      fin();
    end
    we = 1'b0;
    mid();
    chk("ready_busy_b", busy_b, 0);
    chk("ready_busy_n", busy_n, 0);
    fin();

    // every entry reads zero after clearing
    for (int a = 0; a < 8; a++) begin
      ra = {a[2:0], a[2:0]};
      mid();
      chk("clr_val_b", rd_b, 0);
      chk("clr_val_n", rd_n, 0);
      fin();
    end

    // write then read, bypass vs no bypass
    we = 1'b1; wa = 3'd3; wd = 8'hA5;
    ra = {3'd3, 3'd3};
    mid();
    chk("wr_nb_same", rd_n[7:0], 8'h00);
    chk("wr_b_byp0", rd_b[7:0], 8'hA5);
    chk("wr_b_byp1", rd_b[15:8], 8'hA5);
    fin();
    we = 1'b0;
    mid();
    chk("rd_nb_p0", rd_n[7:0], 8'hA5);
    chk("rd_nb_p1", rd_n[15:8], 8'hA5);
    chk("rd_drop0", drop_b, 0);
    fin();

    // bypass on port 0 only
    we = 1'b1; wa = 3'd5; wd = 8'h3C;
    ra = {3'd2, 3'd5};
    mid();
    chk("byp_p0", rd_b[7:0], 8'h3C);
    chk("byp_p1", rd_b[15:8], 8'h00);
    chk("nbyp_p0", rd_n[7:0], 8'h00);
    fin();

    // write to r0 is dropped
    we = 1'b1; wa = 3'd0; wd = 8'hFF;
    ra = {3'd0, 3'd0};
    mid();
    chk("r0_rd_same", rd_b, 0);
    fin();
    we = 1'b0;
    ra = {3'd5, 3'd0};
    mid();
    chk("r0_drop_b", drop_b, 1);
    chk("r0_drop_n", drop_n, 1);
    chk("r0_rd", rd_b[7:0], 8'h00);
    chk("r5_nb", rd_n[15:8], 8'h3C);
    fin();
    mid();
    chk("r0_drop_off", drop_b, 0);
    fin();

    // parity injection on entry 6
    we = 1'b1; wa = 3'd6; wd = 8'h81;
    par_inject = 1'b1;
    ra = {3'd3, 3'd3};
    mid();
    chk("par_pre", perr_b, 0);
    fin();
    we = 1'b0; par_inject = 1'b0;
    ra = {3'd6, 3'd3};
    mid();
    chk("par_data", rd_b[15:8], 8'h81);
    chk("par_notyet", perr_b, 0);
    fin();
    ra = {3'd3, 3'd3};
    mid();
    chk("par_err_b", perr_b, perr_exp);
    chk("par_err_n", perr_n, perr_exp);
    fin();
    mid();
    chk("par_sticky", perr_b, perr_exp);
    fin();

    // r2 = 0x77, then reset with a simultaneous write
    we = 1'b1; wa = 3'd2; wd = 8'h77;
    ra = {3'd2, 3'd2};
    fin();
    we = 1'b0;
    mid();
    chk("r2_val", rd_n[7:0], 8'h77);
    fin();
    reset = 1'b1;
    we = 1'b1; wa = 3'd7; wd = 8'h55;
    fin();
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rc_busy", busy_b, 1);
      if (i == 0) begin
        chk("rst_wr_nodrop", drop_b, 0);
        chk("rst_perr_clr", perr_b, 0);
      end
      fin();
    end

    // reset again at clear cycle 4
    reset = 1'b1;
    mid();
    chk("rc4_busy", busy_b, 1);
    fin();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("rc_busy_b", busy_b, 1);
      chk("rc_busy_n", busy_n, 1);
      fin();
    end
    ra = {3'd7, 3'd2};
    mid();
    chk("rc_done", busy_b, 0);
    chk("rc_r2_b", rd_b[7:0], 8'h00);
    chk("rc_r2_n", rd_n[7:0], 8'h00);
    chk("rc_r7", rd_n[15:8], 8'h00);
    fin();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
